// File: rtl/tsn_strict_pri_sched_if.sv
// Shaper-facing handshake bundle of the strict-priority grant stage.
// i_queue_vld qualifies i_queue/i_gate_* for one cycle; o_scheduing_rst_vld marks a new grant (or all-zero refusal).
interface tsn_strict_pri_sched_if #(
  parameter int N = 8
);
  logic [N-1:0] i_queue;
  logic         i_queue_vld;
  logic         i_gate_en;
  logic [N-1:0] i_gate_state;
  logic [N-1:0] o_scheduing_rst;
  logic         o_scheduing_rst_vld;
  logic         o_send_flag;

  modport master (
    output i_queue, i_queue_vld, i_gate_en, i_gate_state,
    input  o_scheduing_rst, o_scheduing_rst_vld, o_send_flag
  );

  modport slave (
    input  i_queue, i_queue_vld, i_gate_en, i_gate_state,
    output o_scheduing_rst, o_scheduing_rst_vld, o_send_flag
  );
endinterface

// File: rtl/tsn_strict_pri_sched.sv
// Strict-priority grant stage: masks shaper eligibility with TAS gates, grants the top queue
// for a whole MAC frame, and keeps saturating per-queue transmitted-frame counters.
module tsn_strict_pri_sched #(
  parameter int PORT_FIFO_PRI_NUM = 8,
  parameter int GRANT_TIMEOUT     = 1024,
  parameter int CNT_WIDTH         = 32,
  localparam int N     = PORT_FIFO_PRI_NUM,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1,
  localparam int TMO_W = $clog2(GRANT_TIMEOUT) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  tsn_strict_pri_sched_if.slave sched,
  input  logic                 i_mac_tx_axis_valid,
  input  logic                 i_mac_tx_axis_last,
  input  logic [SEL_W-1:0]     i_cnt_sel,
  input  logic                 i_cnt_clr,
  output logic                 o_timeout,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_cnt_data,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, GRANT = 2'd2, XMIT = 2'd3} state_t;

  state_t               state, state_d;
  logic [N-1:0]         r_elig, elig_d;
  logic [N-1:0]         r_grant, grant_d;
  logic                 r_grant_vld, grant_vld_d;
  logic                 r_send, send_d;
  logic                 r_tmo, tmo_d;
  logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_d;
  logic [SEL_W-1:0]     r_idx, idx_d;
  logic [SEL_W-1:0]     hi_idx;
  logic                 frame_done;
  logic [CNT_WIDTH-1:0] cnt [N];

  // Highest set bit wins: later iterations overwrite lower indices.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_elig[i]) hi_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_d     = state;
    elig_d      = r_elig;
    grant_d     = r_grant;
    grant_vld_d = 1'b0;
    send_d      = 1'b0;
    tmo_d       = 1'b0;
    tmo_cnt_d   = tmo_cnt;
    idx_d       = r_idx;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (sched.i_queue_vld) begin
          elig_d  = sched.i_queue & (sched.i_gate_en ? sched.i_gate_state : {N{1'b1}});
          state_d = ARB;
        end
      end
      ARB: begin
        grant_vld_d = 1'b1;
        if (r_elig == '0) begin
          grant_d = '0;
          state_d = IDLE;
        end else begin
          grant_d   = {{(N-1){1'b0}}, 1'b1} << hi_idx;
          idx_d     = hi_idx;
          tmo_cnt_d = '0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (i_mac_tx_axis_valid) begin
          send_d = 1'b1;
          if (i_mac_tx_axis_last) begin
            frame_done = 1'b1;
            grant_d    = '0;
            state_d    = IDLE;
          end else begin
            state_d = XMIT;
          end
        end else if (tmo_cnt == TMO_W'(GRANT_TIMEOUT - 1)) begin
          grant_d = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end
      XMIT: begin
        // Grant is still visible during the last beat so the shaper can release credit on last & grant.
        if (i_mac_tx_axis_valid && i_mac_tx_axis_last) begin
          frame_done = 1'b1;
          grant_d    = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      r_elig      <= '0;
      r_grant     <= '0;
      r_grant_vld <= 1'b0;
      r_send      <= 1'b0;
      r_tmo       <= 1'b0;
      tmo_cnt     <= '0;
      r_idx       <= '0;
    end else begin
      state       <= state_d;
      r_elig      <= elig_d;
      r_grant     <= grant_d;
      r_grant_vld <= grant_vld_d;
      r_send      <= send_d;
      r_tmo       <= tmo_d;
      tmo_cnt     <= tmo_cnt_d;
      r_idx       <= idx_d;
    end
  end

  // Clear beats a coincident increment; counters stick at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      o_cnt_data <= '0;
    end else begin
      if (i_cnt_clr) begin
        for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else if (frame_done && (cnt[r_idx] != {CNT_WIDTH{1'b1}})) begin
        cnt[r_idx] <= cnt[r_idx] + 1'b1;
      end
      o_cnt_data <= cnt[i_cnt_sel];
    end
  end

  assign sched.o_scheduing_rst     = r_grant;
  assign sched.o_scheduing_rst_vld = r_grant_vld;
  assign sched.o_send_flag         = r_send;
  assign o_timeout                 = r_tmo;
  assign o_busy                    = (state != IDLE);
  assign o_dbg_state               = state;

endmodule

// File: tb/tb_tsn_strict_pri_sched.sv
// Bench for tsn_strict_pri_sched: directed scenarios plus randomized grants, with a
// grant scoreboard (exp_q) and a per-queue frame-count reference model.
module tb_tsn_strict_pri_sched;
  localparam int N   = 8;
  localparam int TMO = 1024;
  localparam int CW  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #2 clk = ~clk;

  logic          mac_valid, mac_last, cnt_clr;
  logic [2:0]    cnt_sel;
  logic          o_timeout, o_busy;
  logic [CW-1:0] o_cnt_data;
  logic [1:0]    o_dbg_state;

  tsn_strict_pri_sched_if #(.N(N)) sif ();

  tsn_strict_pri_sched #(
    .PORT_FIFO_PRI_NUM(N), .GRANT_TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .sched(sif),
    .i_mac_tx_axis_valid(mac_valid), .i_mac_tx_axis_last(mac_last),
    .i_cnt_sel(cnt_sel), .i_cnt_clr(cnt_clr),
    .o_timeout(o_timeout), .o_busy(o_busy), .o_cnt_data(o_cnt_data),
    .o_dbg_state(o_dbg_state)
  );

  int tests = 0;
  int fails = 0;
  logic [N-1:0] exp_q[$];
  int sf_cnt = 0;
  int to_cnt = 0;
  int exp_cnt[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: gate-masked eligibility, highest index wins.
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] q, input logic gen,
                                               input logic [N-1:0] gs);
    logic [N-1:0] m;
    logic [N-1:0] one;
    m   = gen ? (q & gs) : q;
    one = 1;
    for (int i = N - 1; i >= 0; i--) if (m[i]) return one << i;
    return '0;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.o_scheduing_rst_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", 32'(sif.o_scheduing_rst_vld), 32'd0);
        end else begin
          chk("grant_value", 32'(sif.o_scheduing_rst), 32'(exp_q.pop_front()));
        end
      end
      if (sif.o_send_flag) sf_cnt++;
      if (o_timeout) to_cnt++;
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] q, input logic gen, input logic [N-1:0] gs,
                       output logic [N-1:0] g);
    g = model_grant(q, gen, gs);
    exp_q.push_back(g);
    sif.i_queue      = q;
    sif.i_gate_en    = gen;
    sif.i_gate_state = gs;
    sif.i_queue_vld  = 1'b1;
    tick();
    sif.i_queue_vld  = 1'b0;
    chk("busy_arb", 32'(o_busy), 32'd1);
    tick();
    chk("vld_latency", 32'(sif.o_scheduing_rst_vld), 32'd1);
    chk("busy_after_arb", 32'(o_busy), (g == '0) ? 32'd0 : 32'd1);
  endtask

  task automatic frame(input logic [N-1:0] g, input int nbeats, input logic clr, input logic inj);
    int sf0;
    sf0 = sf_cnt;
    repeat ($urandom_range(0, 5)) tick();
    for (int b = 0; b < nbeats; b++) begin
      mac_valid = 1'b1;
      mac_last  = (b == nbeats - 1);
      cnt_clr   = clr && (b == nbeats - 1);
      if (inj && ($urandom_range(0, 1) == 1)) begin
        sif.i_queue     = N'($urandom_range(1, 255));
        sif.i_gate_en   = 1'b0;
        sif.i_queue_vld = 1'b1;
      end
      chk("grant_held", 32'(sif.o_scheduing_rst), 32'(g));
      tick();
      sif.i_queue_vld = 1'b0;
      cnt_clr         = 1'b0;
      if (b == 0) chk("send_flag_first", 32'(sif.o_send_flag), 32'd1);
      if (b != nbeats - 1) begin
        mac_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    mac_valid = 1'b0;
    mac_last  = 1'b0;
    chk("grant_clear", 32'(sif.o_scheduing_rst), 32'd0);
    chk("busy_end", 32'(o_busy), 32'd0);
    tick();
    chk("send_flag_count", 32'(sf_cnt - sf0), 32'd1);
    if (clr) begin
      for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    end else if (exp_cnt[onehot_idx(g)] < (1 << CW) - 1) begin
      exp_cnt[onehot_idx(g)]++;
    end
  endtask

  task automatic read_cnt(input int idx);
    cnt_sel = 3'(idx);
    tick();
    chk($sformatf("cnt_q%0d", idx), 32'(o_cnt_data), 32'(exp_cnt[idx]));
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] rq, rgs;
    logic         rgen;
    int           sf0, to0;

    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    rst_n = 1'b0;
    sif.i_queue = '0; sif.i_queue_vld = 1'b0; sif.i_gate_en = 1'b0; sif.i_gate_state = '0;
    mac_valid = 1'b0; mac_last = 1'b0; cnt_sel = '0; cnt_clr = 1'b0;
    repeat (3) tick();
    chk("rst_grant", 32'(sif.o_scheduing_rst), 32'd0);
    chk("rst_vld", 32'(sif.o_scheduing_rst_vld), 32'd0);
    chk("rst_send", 32'(sif.o_send_flag), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cnt", 32'(o_cnt_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic grant
    issue(8'b0010_0110, 1'b0, 8'h00, g);
    frame(g, 4, 1'b0, 1'b0);
    read_cnt(5);

    // gate mask, then gate closing every eligible queue
    issue(8'hC0, 1'b1, 8'h40, g);
    frame(g, 2, 1'b0, 1'b0);
    sf0 = sf_cnt;
    issue(8'hC0, 1'b1, 8'h0F, g);
    repeat (3) tick();
    chk("no_send_on_zero", 32'(sf_cnt - sf0), 32'd0);

    // timeout
    to0 = to_cnt;
    issue(8'h81, 1'b0, 8'h00, g);
    repeat (TMO - 1) tick();
    chk("timeout_early", 32'(o_timeout), 32'd0);
    chk("grant_before_timeout", 32'(sif.o_scheduing_rst), 32'(g));
    tick();
    chk("timeout_pulse", 32'(o_timeout), 32'd1);
    chk("grant_after_timeout", 32'(sif.o_scheduing_rst), 32'd0);
    tick();
    chk("timeout_count", 32'(to_cnt - to0), 32'd1);
    chk("busy_after_timeout", 32'(o_busy), 32'd0);
    read_cnt(7);
    issue(8'h81, 1'b0, 8'h00, g);
    frame(g, 2, 1'b0, 1'b0);

    // single-beat frames and vld pulses that must be ignored
    issue(8'h04, 1'b0, 8'h00, g);
    frame(g, 1, 1'b0, 1'b1);
    issue(8'h18, 1'b0, 8'h00, g);
    frame(g, 3, 1'b0, 1'b1);
    read_cnt(2);
    read_cnt(4);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      rq   = N'($urandom_range(0, 255));
      rgen = 1'($urandom_range(0, 1));
      rgs  = N'($urandom_range(0, 255));
      issue(rq, rgen, rgs, g);
      if (g != '0) frame(g, $urandom_range(1, 4), 1'b0, 1'($urandom_range(0, 1)));
      read_cnt($urandom_range(0, N - 1));
    end

    // saturation, then clear coinciding with a last beat
    for (int k = 0; k < 17; k++) begin
      issue(8'h08, 1'b0, 8'h00, g);
      frame(g, 1, 1'b0, 1'b0);
    end
    read_cnt(3);
    chk("cnt_saturated", 32'(o_cnt_data), 32'd15);
    issue(8'h08, 1'b0, 8'h00, g);
    frame(g, 2, 1'b1, 1'b0);
    read_cnt(3);
    read_cnt(5);

    // asynchronous reset during XMIT
    issue(8'h20, 1'b0, 8'h00, g);
    mac_valid = 1'b1;
    mac_last  = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("amid_grant", 32'(sif.o_scheduing_rst), 32'd0);
    chk("amid_send", 32'(sif.o_send_flag), 32'd0);
    chk("amid_busy", 32'(o_busy), 32'd0);
    chk("amid_cnt", 32'(o_cnt_data), 32'd0);
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    mac_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    read_cnt(3);
    issue(8'h02, 1'b0, 8'h00, g);
    frame(g, 3, 1'b0, 1'b0);
    read_cnt(1);

    tick();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tsn_strict_pri_sched.md
# tsn_strict_pri_sched

Strict-priority grant stage of the TXMAC scheduling pipeline. It sits directly downstream of the credit-based-shaper manager. It takes that stage's per-queue eligibility vector, masks it with the TAS gate state, and grants the highest-priority eligible queue. It holds the one-hot grant for the whole frame on the MAC AXIS stream, and returns the grant and a send-start pulse upstream so shaper credits are debited correctly. It also keeps per-queue transmitted-frame counters.

## Interface
- PORT_FIFO_PRI_NUM, 8, number of priority queues; index N-1 is highest priority.
- GRANT_TIMEOUT, 1024, cycles to wait in GRANT for the first MAC beat before abandoning the grant.
- CNT_WIDTH, 32, width of each per-queue frame counter.

- i_clk  in  1  250 MHz clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_queue  in  N  eligible-queue vector from the shaper manager.
- i_queue_vld  in  1  single-cycle qualifier for i_queue.
- i_gate_en  in  1  1 = apply i_gate_state mask.
- i_gate_state  in  N  TAS gate-open mask.
- i_mac_tx_axis_valid  in  1  MAC TX stream beat valid.
- i_mac_tx_axis_last  in  1  MAC TX stream last beat.
- i_cnt_sel  in  clog2(N)  counter read select.
- i_cnt_clr  in  1  synchronous clear of all counters.
- o_scheduing_rst  out  N  one-hot grant, held for the whole frame; all-zero = no grant.
- o_scheduing_rst_vld  out  1  single-cycle pulse when a new decision is placed on o_scheduing_rst.
- o_send_flag  out  1  single-cycle pulse on the first MAC beat of a granted frame.
- o_timeout  out  1  single-cycle pulse when a grant is abandoned.
- o_busy  out  1  high in states ARB, GRANT and XMIT.
- o_cnt_data  out  CNT_WIDTH  registered counter value for i_cnt_sel.

## Operation
- Reset values: all outputs 0, FSM in IDLE, counters 0, timeout counter 0.
- **IDLE**
  - On i_queue_vld, capture r_elig = i_queue & (i_gate_en ? i_gate_state : all-ones).
  - Go to ARB.
- **ARB** (always one cycle)
  - If r_elig == 0: register o_scheduing_rst = 0, pulse o_scheduing_rst_vld, go to IDLE. The upstream shaper uses this zero result to drop its schedule request.
  - Else: register the one-hot of the highest set index of r_elig, pulse o_scheduing_rst_vld, clear the timeout counter, go to GRANT.
- **GRANT**
  - On i_mac_tx_axis_valid: pulse o_send_flag and go to XMIT. If valid and last arrive in the same cycle (single-beat frame), go straight to frame-end handling.
  - Else increment the timeout counter.
  - When the counter reaches GRANT_TIMEOUT-1 with no beat: clear o_scheduing_rst, pulse o_timeout, go to IDLE.
- **XMIT**
  - On i_mac_tx_axis_valid & i_mac_tx_axis_last: increment the counter of the granted queue and go to IDLE.
  - o_scheduing_rst stays asserted through the last-beat cycle and clears on the following edge. The shaper qualifies its credit release with last & grant in the same cycle, so this ordering is required.
- i_queue_vld outside IDLE is ignored, including in the cycle XMIT exits.
- Counters saturate at all-ones and do not wrap.
- i_cnt_clr has priority over a simultaneous increment; the result is 0.
- o_cnt_data = counter[i_cnt_sel], registered, one cycle latency.
- i_gate_state is sampled only at capture. Gate changes mid-frame do not revoke the grant.
- Asynchronous reset mid-frame returns to IDLE with all outputs 0 immediately. Counters are cleared.

## Timing
- i_queue_vld in cycle n: ARB in cycle n+1; o_scheduing_rst and o_scheduing_rst_vld valid in cycle n+2.
- First MAC valid in cycle m while in GRANT: o_send_flag high in cycle m+1.
- Last beat in cycle k: o_scheduing_rst = 0 and IDLE in cycle k+1. The next i_queue_vld is accepted from cycle k+1.
- Timeout: o_timeout high exactly GRANT_TIMEOUT cycles after the o_scheduing_rst_vld cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- **Basic grant.** i_queue=8'b0010_0110, gate disabled -> o_scheduing_rst=8'b0010_0000 with a vld pulse 2 cycles after i_queue_vld. A 4-beat frame -> o_send_flag pulses once; grant clears the cycle after last; counter[5]=1.
- **Gate mask.** i_queue=8'hC0, i_gate_en=1, i_gate_state=8'h40 -> grant 8'h40. With i_gate_state=8'h0F -> o_scheduing_rst=0 with a vld pulse; FSM back to IDLE, no o_send_flag.
- **Timeout.** Grant issued, no MAC valid -> o_timeout pulses after 1024 cycles, grant clears, counter unchanged. A following i_queue_vld is accepted.
- **Single-beat frame and ignored vld.** valid and last in the same cycle -> o_send_flag pulses, counter increments, IDLE next cycle. An i_queue_vld pulse during XMIT produces no o_scheduing_rst_vld.
- **Counter saturation and clear.** Preload via 2^CNT_WIDTH frames (CNT_WIDTH=4 for sim) -> counter holds 15. i_cnt_clr together with a last beat -> counter reads 0 one cycle after i_cnt_sel.
- **Reset mid-frame.** Assert i_rst_n=0 during XMIT -> all outputs 0 immediately. After release, a new grant works normally.
